// File: rtl/wall_scroller_if.sv
// Frame-advance handshake and wall-state bus between game control, wall_scroller and the drawing datapath.
interface wall_scroller_if #(
   parameter int NUM_WALLS = 2,
   parameter int X_W       = 8
);
   logic                     tick;
   logic [3:0]               speed;
   logic [NUM_WALLS*X_W-1:0] wall_x;
   logic [NUM_WALLS*7-1:0]   hole_y;
   logic                     busy;
   logic                     done;
   logic [NUM_WALLS-1:0]     respawn;
   logic                     score_pulse;
   logic                     overrun;

   modport master (
      output tick, speed,
      input  wall_x, hole_y, busy, done, respawn, score_pulse, overrun
   );

   modport slave (
      input  tick, speed,
      output wall_x, hole_y, busy, done, respawn, score_pulse, overrun
   );
endinterface

// File: rtl/wall_scroller.sv
// Multi-wall obstacle engine: on each tick walks the walls one per clock, scrolling left and wrapping.
// Define WALL_SCROLLER_LFSR_EN to draw new hole positions from an LFSR instead of a fixed +24 step.
module wall_scroller #(
   parameter int NUM_WALLS    = 2,
   parameter int X_W          = 8,
   parameter int SCREEN_W     = 160,
   parameter int WALL_SPACING = 80,
   parameter int HOLE_Y_MAX   = 80,
   parameter int BIRD_X       = 40
) (
   input logic            clk,
   input logic            reset,
   wall_scroller_if.slave bus
);
   localparam int                 IDX_W    = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_WALLS - 1);
   localparam logic [X_W-1:0]     SPAN     = X_W'(NUM_WALLS * WALL_SPACING);
   localparam logic [X_W-1:0]     BIRD     = X_W'(BIRD_X);
   localparam logic [7:0]         HOLE_MAX = 8'(HOLE_Y_MAX);
   localparam logic [6:0]         HOLE_RST = 7'(HOLE_Y_MAX / 2);

   typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

   state_t               r_state, w_next;
   logic [X_W-1:0]       r_wall_x [NUM_WALLS];
   logic [6:0]           r_hole_y [NUM_WALLS];
   logic [IDX_W-1:0]     r_idx;
   logic [3:0]           r_spd;
   logic [NUM_WALLS-1:0] r_resp_acc;
   logic                 r_score_acc;
   logic                 r_busy, r_done, r_score, r_overrun;
   logic [NUM_WALLS-1:0] r_respawn;

   logic [X_W-1:0]       w_x, w_spd, w_new_x;
   logic                 w_wrap, w_cross;
   logic [NUM_WALLS-1:0] w_wrap_bit;
   logic [7:0]           w_hole_sum;
   logic [6:0]           w_new_hole;

`ifdef WALL_SCROLLER_LFSR_EN
   logic [7:0] r_lfsr;
   logic [7:0] w_c;

   // Free-running x^8+x^6+x^5+x^4+1 source; it also steps while idle so holes vary with frame timing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_lfsr <= 8'hA5;
      else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
   end

   always_comb begin
      w_c        = {1'b0, r_lfsr[6:0]};
      w_hole_sum = (w_c <= HOLE_MAX) ? w_c : w_c - (HOLE_MAX + 8'd1);
   end
`else
   always_comb begin
      w_hole_sum = {1'b0, r_hole_y[r_idx]} + 8'd24;
      if (w_hole_sum > HOLE_MAX) w_hole_sum = w_hole_sum - (HOLE_MAX + 8'd1);
   end
`endif

   assign w_new_hole = w_hole_sum[6:0];

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (bus.tick) w_next = S_UPDATE;
         S_UPDATE: if (r_idx == LAST_IDX) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Wrapping adds the full queue span so the gap to the wall in front stays exact.
   always_comb begin
      w_spd      = X_W'(r_spd);
      w_x        = r_wall_x[r_idx];
      w_wrap     = (w_x < w_spd);
      w_new_x    = w_wrap ? (w_x + SPAN - w_spd) : (w_x - w_spd);
      w_cross    = !w_wrap && (w_x >= BIRD) && (w_new_x < BIRD);
      w_wrap_bit = w_wrap ? (NUM_WALLS'(1) << r_idx) : '0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_spd       <= '0;
         r_resp_acc  <= '0;
         r_score_acc <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_score     <= 1'b0;
         r_overrun   <= 1'b0;
         r_respawn   <= '0;
         // NOTE: the wall arrays are reset because their contents are directly visible game state.
         for (int i = 0; i < NUM_WALLS; i++) begin
            r_wall_x[i] <= X_W'(SCREEN_W + i * WALL_SPACING);
            r_hole_y[i] <= HOLE_RST;
         end
      end else begin
         r_state   <= w_next;
         r_busy    <= (w_next != S_IDLE);
         r_overrun <= bus.tick && (r_state != S_IDLE);
         r_done    <= 1'b0;
         r_score   <= 1'b0;
         r_respawn <= '0;
         case (r_state)
            S_IDLE: begin
               if (bus.tick) begin
                  r_spd       <= bus.speed;
                  r_idx       <= '0;
                  r_resp_acc  <= '0;
                  r_score_acc <= 1'b0;
               end
            end
            S_UPDATE: begin
               r_wall_x[r_idx] <= w_new_x;
               if (w_wrap) r_hole_y[r_idx] <= w_new_hole;
               r_resp_acc  <= r_resp_acc | w_wrap_bit;
               r_score_acc <= r_score_acc | w_cross;
               if (r_idx == LAST_IDX) begin
                  r_done    <= 1'b1;
                  r_respawn <= r_resp_acc | w_wrap_bit;
                  r_score   <= r_score_acc | w_cross;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_WALLS; g++) begin : g_pack
      assign bus.wall_x[g*X_W +: X_W] = r_wall_x[g];
      assign bus.hole_y[g*7 +: 7]     = r_hole_y[g];
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.respawn     = r_respawn;
   assign bus.score_pulse = r_score;
   assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_wall_scroller.sv
// Self-checking bench for wall_scroller: frame-level arithmetic model compared every cycle plus directed literals.
module tb_wall_scroller;
   localparam int N  = 2;
   localparam int XW = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   wall_scroller_if #(.NUM_WALLS(N), .X_W(XW)) sif ();

   wall_scroller #(
      .NUM_WALLS(N), .X_W(XW), .SCREEN_W(160), .WALL_SPACING(80),
      .HOLE_Y_MAX(80), .BIRD_X(40)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: a frame takes N+1 cycles after the accepted tick; wall i gets its new value at the (i+1)th edge.
   int         m_x [N];
   int         m_h [N];
   int         m_left;
   int         m_spd;
   bit [N-1:0] m_resp;
   bit         m_score;
   bit         m_ovr;
   logic [7:0] m_lfsr;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            m_x[i] = 160 + i * 80;
            m_h[i] = 40;
         end
         m_left = 0; m_spd = 0; m_resp = '0; m_score = 0; m_ovr = 0;
         m_lfsr = 8'hA5;
      end else begin
         m_ovr = 0;
         if (m_left == 0) begin
            if (sif.tick) begin
               m_spd = sif.speed; m_left = N + 1; m_resp = '0; m_score = 0;
            end
         end else begin
            if (sif.tick) m_ovr = 1;
            if (m_left >= 2) begin
               int i, x, nx, nh, c;
               i = N + 1 - m_left;
               x = m_x[i];
               if (x >= m_spd) begin
                  nx = x - m_spd;
                  if (x >= 40 && nx < 40) m_score = 1;
               end else begin
                  nx = (x + N * 80 - m_spd) % 256;
                  m_resp[i] = 1'b1;
`ifdef WALL_SCROLLER_LFSR_EN
                  c  = int'(m_lfsr[6:0]);
                  nh = (c <= 80) ? c : c - 81;
`else
                  c  = 0;
                  nh = m_h[i] + 24;
                  if (nh > 80) nh = nh - 81;
`endif
                  m_h[i] = nh + c * 0;
               end
               m_x[i] = nx;
            end
            m_left--;
         end
         m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end
   end

   always @(negedge clk) begin
      logic [N*XW-1:0] ex_x;
      logic [N*7-1:0]  ex_h;
      bit              ex_done;
      for (int i = 0; i < N; i++) begin
         ex_x[i*XW +: XW] = XW'(m_x[i]);
         ex_h[i*7 +: 7]   = 7'(m_h[i]);
      end
      ex_done = (m_left == 1);
      check("wall_x",  int'(sif.wall_x), int'(ex_x));
      check("hole_y",  int'(sif.hole_y), int'(ex_h));
      check("busy",    int'(sif.busy), int'(m_left > 0));
      check("done",    int'(sif.done), int'(ex_done));
      check("overrun", int'(sif.overrun), int'(m_ovr));
      check("respawn", int'(sif.respawn), ex_done ? int'(m_resp) : 0);
      check("score",   int'(sif.score_pulse), ex_done ? int'(m_score) : 0);
   end

   task automatic frame(input int spd, output int lat, output int busy_n,
                        output int resp, output int score);
      @(negedge clk);
      sif.tick  = 1'b1;
      sif.speed = 4'(spd);
      @(negedge clk);
      sif.tick = 1'b0;
      lat = 1; busy_n = 0;
      while (!sif.done && lat < 12) begin
         if (sif.busy) busy_n++;
         @(negedge clk);
         lat++;
      end
      if (sif.busy) busy_n++;
      resp  = int'(sif.respawn);
      score = int'(sif.score_pulse);
   endtask

   task automatic run_frame(input int spd);
      int lat, bn, rs, sc;
      frame(spd, lat, bn, rs, sc);
      check("frame_latency", lat, 3);
   endtask

   initial begin
      int lat, bn, rs, sc, ov, dn;
      sif.tick  = 1'b0;
      sif.speed = 4'd0;
      repeat (2) @(negedge clk);
      check("rst_wall_x", int'(sif.wall_x), 16'hF0A0);
      check("rst_hole_y", int'(sif.hole_y), (40 << 7) | 40);
      #2 reset = 1'b0;

      frame(4, lat, bn, rs, sc);
      check("t1_latency", lat, 3);
      check("t1_busy_cycles", bn, 3);
      check("t1_wall_x", int'(sif.wall_x), 16'hEC9C);
      check("t1_respawn", rs, 0);

      frame(0, lat, bn, rs, sc);
      check("spd0_latency", lat, 3);
      check("spd0_wall_x", int'(sif.wall_x), 16'hEC9C);

      repeat (10) run_frame(15);
      run_frame(4);
      check("pre_wrap_wall0", int'(sif.wall_x[7:0]), 2);

      frame(4, lat, bn, rs, sc);
      check("wrap_wall0", int'(sif.wall_x[7:0]), 158);
      check("wrap_respawn", rs, 1);
      check("wrap_score", sc, 0);
`ifdef WALL_SCROLLER_LFSR_EN
      check("wrap_hole_range", int'(sif.hole_y[6:0] <= 7'd80), 1);
`else
      check("wrap_hole0", int'(sif.hole_y[6:0]), 64);
`endif

      repeat (7) run_frame(15);
      run_frame(11);
      check("pre_score_wall0", int'(sif.wall_x[7:0]), 42);
      frame(4, lat, bn, rs, sc);
      check("score_wall0", int'(sif.wall_x[7:0]), 38);
      check("score_hit", sc, 1);
      frame(4, lat, bn, rs, sc);
      check("score_wall0_again", int'(sif.wall_x[7:0]), 34);
      check("score_miss", sc, 0);

      @(negedge clk);
      sif.tick = 1'b1; sif.speed = 4'd4;
      ov = 0; dn = 0;
      repeat (3) begin
         @(negedge clk);
         if (sif.overrun) ov++;
         if (sif.done) dn++;
      end
      sif.tick = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (sif.overrun) ov++;
         if (sif.done) dn++;
      end
      check("overrun_pulses", ov, 2);
      check("overrun_dones", dn, 1);
      check("overrun_wall0", int'(sif.wall_x[7:0]), 30);

      @(negedge clk);
      sif.tick = 1'b1; sif.speed = 4'd4;
      @(negedge clk);
      sif.tick = 1'b0;
      @(posedge clk);
      #1 check("mid_wall0_written", int'(sif.wall_x[7:0]), 26);
      #1 reset = 1'b1;
      #1 check("mid_rst_wall_x", int'(sif.wall_x), 16'hF0A0);
      check("mid_rst_hole_y", int'(sif.hole_y), (40 << 7) | 40);
      check("mid_rst_busy", int'(sif.busy), 0);
      @(negedge clk);
      #2 reset = 1'b0;
      dn = 0;
      repeat (6) begin
         @(negedge clk);
         if (sif.done) dn++;
      end
      check("mid_rst_no_done", dn, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/wall_scroller.md
# wall_scroller

Parametrised multi-wall obstacle engine for the side-scrolling game datapath. It holds NUM_WALLS wall x-positions and hole y-positions. On each frame tick it walks the walls serially, one per clock, and moves each one left by a runtime speed. A wall that would underflow the left edge wraps to the back of the queue and gets a new hole position. The block sits between the game control FSM (which supplies `tick` and consumes `done`) and the VGA drawing datapath and score counter.

## Interface
- NUM_WALLS, 2: walls tracked; 1–4.
- X_W, 8: x-coordinate width.
- SCREEN_W, 160: spawn x of wall 0 at reset.
- WALL_SPACING, 80: x distance between consecutive walls. Constraint: SCREEN_W + (NUM_WALLS-1)*WALL_SPACING < 2^X_W.
- HOLE_Y_MAX, 80: largest hole top y; must lie in 64..127.
- BIRD_X, 40: x column used for score detection.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle frame-advance request.
- speed  in  4  pixels per frame, sampled when tick is accepted.
- wall_x  out  NUM_WALLS*X_W  packed x-positions; wall i occupies bits [i*X_W +: X_W].
- hole_y  out  NUM_WALLS*7  packed hole-top y-positions.
- busy  out  1  high while an update is in progress.
- done  out  1  one-cycle pulse when an update completes.
- respawn  out  NUM_WALLS  per-wall flag; set for the frame in which that wall wrapped, valid while done=1.
- score_pulse  out  1  high with done if any wall crossed BIRD_X this frame.
- overrun  out  1  one-cycle pulse when tick arrives while busy.

## Operation
- FSM states: IDLE, UPDATE, DONE.
  - IDLE: tick=1 → latch speed into spd_r, clear idx, clear the respawn and score accumulators, go to UPDATE.
  - UPDATE: process wall idx; if idx==NUM_WALLS-1 go to DONE, otherwise idx+1.
  - DONE: assert done for one cycle, then go to IDLE.
- Per-wall update, with x = wall_x[idx]:
  - If x >= spd_r: new x = x - spd_r.
  - Otherwise (wrap): new x = x + NUM_WALLS*WALL_SPACING - spd_r (mod 2^X_W). Hole is reloaded from the hole source and respawn[idx] is set. This keeps spacing exact.
  - Score: if no wrap, x >= BIRD_X and new x < BIRD_X, set the score accumulator. A wrapping wall never scores.
  - speed=0: no wall moves, the update still runs, and done still pulses.
- Hole source:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1. Seed 8'hA5 on reset. Advances every clock, including in IDLE.
  - Let c = lfsr[6:0]. Hole = c if c <= HOLE_Y_MAX, else c - (HOLE_Y_MAX+1).
- tick in UPDATE or DONE: ignored and overrun pulses. There is no queuing.
- Reset values (asynchronous, immediate, including mid-update):
  - wall_x[i] = SCREEN_W + i*WALL_SPACING.
  - hole_y[i] = HOLE_Y_MAX/2.
  - State IDLE; busy, done, respawn, score_pulse and overrun = 0.
  - LFSR = 8'hA5.

## Timing
- tick is sampled at edge k while in IDLE.
- wall i is written at edge k+1+i.
- busy is high from after edge k until DONE exits.
- done, respawn and score_pulse are high for exactly the cycle after edge k+NUM_WALLS.
- Latency from tick to done = NUM_WALLS+1 cycles. The next tick is accepted in the cycle done is high's successor, IDLE.
- All outputs are registered. wall_x and hole_y change only at write edges, so drawing logic reads stable values whenever busy=0.
- overrun pulses in the cycle after the offending tick edge.

## Configuration
- WALL_SCROLLER_LFSR_EN defined: holes come from the LFSR as described.
- WALL_SCROLLER_LFSR_EN undefined: the LFSR is removed and holes are deterministic.
  - New hole = previous hole of that wall + 24.
  - If the result exceeds HOLE_Y_MAX, subtract HOLE_Y_MAX+1.
  - Example with defaults: 40 → 64 → 7.

## Test plan
- Reset with defaults → wall_x = {240,160}, hole_y = {40,40}, all flags 0.
- tick with speed=4 → done exactly 3 cycles after the tick edge; wall_x = {236,156}, busy was high 3 cycles, no respawn.
- Force wall 0 to x=2, speed=4, tick → wall0 = 158, respawn[0]=1 with done. Undefined macro: hole0 = 64. Defined macro: hole0 in 0..80.
- Wall 0 at x=42, speed=4, tick → wall0 = 38 and score_pulse=1 with done. Repeat from 38 → score_pulse=0.
- tick held high 3 consecutive cycles → one update performed, overrun pulses twice, final x decremented by 4 only.
- Assert reset during UPDATE after wall 0 has been written → outputs return to reset values the same cycle; no done pulse follows.
